// File: rtl/badpixel_list_writer.sv
// ============================================================================
// Module   : badpixel_list_writer
// Purpose  : Writes one frame's bad-pixel coordinates into a BRAM list and
//            closes the list with an all-zero terminator entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module badpixel_list_writer #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 256,
    parameter int COORD_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   frame_end,
    input  logic                   det_valid,
    input  logic [COORD_WIDTH-1:0] det_x,
    input  logic [COORD_WIDTH-1:0] det_y,
    output logic                   bram_en,
    output logic                   bram_we,
    output logic [ADDR_WIDTH-1:0]  bram_addr,
    output logic [DATA_WIDTH-1:0]  bram_din,
    output logic [ADDR_WIDTH:0]    list_count,
    output logic                   list_overflow,
    output logic                   list_done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COLLECT   = 2'd1,
        TERMINATE = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] LAST_VALID = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] ONE        = (ADDR_WIDTH+1)'(1);

    state_t                  state_q;
    logic                    en_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   din_q;
    logic [ADDR_WIDTH:0]     count_q;
    logic                    overflow_q;
    logic                    done_q;
    logic                    last_vld_q;
    logic [COORD_WIDTH-1:0]  last_x_q;
    logic [COORD_WIDTH-1:0]  last_y_q;

    logic [DATA_WIDTH-1:0]   entry_d;
    logic                    dup_d;

    always_comb begin
        entry_d                     = '0;
        entry_d[31]                 = 1'b1;
        entry_d[16 +: COORD_WIDTH]  = det_y;
        entry_d[0 +: COORD_WIDTH]   = det_x;
        dup_d = last_vld_q && (det_x == last_x_q) && (det_y == last_y_q);
    end

    // frame_start overrides every state; rst overrides frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            last_vld_q <= 1'b0;
            last_x_q   <= '0;
            last_y_q   <= '0;
        end else begin
            en_q <= 1'b0;
            if (frame_start) begin
                state_q    <= COLLECT;
                count_q    <= '0;
                overflow_q <= 1'b0;
                done_q     <= 1'b0;
                last_vld_q <= 1'b0;
            end else begin
                case (state_q)
                    COLLECT: begin
                        if (det_valid && !dup_d) begin
                            if (count_q == LAST_VALID) begin
                                overflow_q <= 1'b1;
                            end else begin
                                en_q       <= 1'b1;
                                addr_q     <= count_q[ADDR_WIDTH-1:0];
                                din_q      <= entry_d;
                                count_q    <= count_q + ONE;
                                last_vld_q <= 1'b1;
                                last_x_q   <= det_x;
                                last_y_q   <= det_y;
                            end
                        end
                        if (frame_end) begin
                            state_q <= TERMINATE;
                        end
                    end
                    TERMINATE: begin
                        en_q    <= 1'b1;
                        addr_q  <= count_q[ADDR_WIDTH-1:0];
                        din_q   <= '0;
                        state_q <= DONE;
                    end
                    DONE: begin
                        done_q <= 1'b1;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bram_en       = en_q;
    assign bram_we       = en_q;
    assign bram_addr     = addr_q;
    assign bram_din      = din_q;
    assign list_count    = count_q;
    assign list_overflow = overflow_q;
    assign list_done     = done_q;

endmodule

`default_nettype wire

// File: doc/badpixel_list_writer.md
BADPIXEL_LIST_WRITER -- requirements
Module: badpixel_list_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, BRAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, BRAM address width.
REQ-003 SHALL have parameter DEPTH, default 256, BRAM entries; DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter COORD_WIDTH, default 12, x/y coordinate width; COORD_WIDTH <= 15.
REQ-005 SHALL have clk, input, 1, single clock for all logic.
REQ-006 SHALL have rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have frame_start, input, 1, one-cycle pulse marking the start of a frame.
REQ-008 SHALL have frame_end, input, 1, one-cycle pulse marking the end of a frame.
REQ-009 SHALL have det_valid, input, 1, detector flags the bad pixel presented this cycle.
REQ-010 SHALL have det_x and det_y, input, COORD_WIDTH each, coordinates of the flagged pixel.
REQ-011 SHALL have bram_en, bram_we, output, 1 each, driving BRAM write-port enable and write-enable.
REQ-012 SHALL have bram_addr, output, ADDR_WIDTH, BRAM write address.
REQ-013 SHALL have bram_din, output, DATA_WIDTH, BRAM write data.
REQ-014 SHALL have list_count, output, ADDR_WIDTH+1, valid entries written in the current or last frame.
REQ-015 SHALL have list_overflow, output, 1, sticky flag: detections dropped this frame.
REQ-016 SHALL have list_done, output, 1, level: list and terminator committed.

Function
REQ-017 SHALL implement states IDLE, COLLECT, TERMINATE and DONE.
REQ-018 IDLE: on frame_start, go to COLLECT; frame_end and det_valid ignored.
REQ-019 COLLECT: on frame_end, go to TERMINATE.
REQ-020 TERMINATE: exactly one cycle, then go to DONE.
REQ-021 DONE: on frame_start, go to COLLECT.
REQ-022 frame_start in any state SHALL clear write pointer, list_count, list_overflow, list_done and the duplicate register, then enter COLLECT.
REQ-023 frame_start in COLLECT is a restart: no terminator; list_done stays 0.
REQ-024 Entry format: bit 31 = 1 (valid), bits [16+COORD_WIDTH-1:16] = y, bits [COORD_WIDTH-1:0] = x, other bits 0.
REQ-025 Terminator entry is all zeros.
REQ-026 det_valid accepted in COLLECT only; write presented with bram_en=bram_we=1 exactly one cycle after acceptance (registered outputs, latency 1).
REQ-027 Sustained det_valid every cycle SHALL sustain one write per cycle, with no back-pressure.
REQ-028 Accepted detection with {x,y} equal to the last written entry in this frame SHALL be dropped silently: no write, count unchanged.
REQ-029 Write address = current list_count; list_count increments on each valid-entry write, same cycle the write is presented.
REQ-030 Capacity for valid entries SHALL be DEPTH-1; the last slot is reserved for the terminator.
REQ-031 Accepted non-duplicate detection when list_count == DEPTH-1 SHALL be dropped and SHALL set list_overflow (sticky until frame_start or rst).
REQ-032 Entering TERMINATE SHALL write the terminator at address list_count in the following cycle; list_count unchanged.
REQ-033 list_done rises the cycle after the terminator write and holds until frame_start or rst.
REQ-034 det_valid and frame_end in the same COLLECT cycle: detection written first, terminator on the next cycle at incremented address.
REQ-035 det_valid and frame_start in the same cycle: detection dropped; the new frame begins empty.
REQ-036 frame_start and frame_end in the same cycle: frame_start wins; frame_end ignored.
REQ-037 When not writing, bram_en=bram_we=0, while bram_addr and bram_din hold their last values.

Reset
REQ-038 rst SHALL force IDLE and set bram_en, bram_we, bram_addr, bram_din, list_count, list_overflow and list_done to 0.
REQ-039 rst mid-frame SHALL abort with no further writes; BRAM contents are not cleared.
REQ-040 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-041 Basic: frame_start; det (x=5,y=3), (x=10,y=7); frame_end. Required: writes addr0=0x80030005, addr1=0x8007000A, addr2=0x00000000; list_count=2; list_done=1 two cycles after frame_end.
REQ-042 Duplicate: det (4,4) on two consecutive cycles. Required: one write; list_count=1.
REQ-043 Overflow (DEPTH=256): 300 distinct detections, then frame_end. Required: list_count=255; list_overflow=1; terminator at addr 255.
REQ-044 Coincident events: det (1,2) with frame_end in the same cycle. Required: entry at addr N, then terminator at N+1.
REQ-045 Restart/reset: frame_start during COLLECT after 3 entries. Required: count 0, no terminator, list_done=0, next entry at addr0. rst mid-frame: all outputs 0, state IDLE, det_valid ignored until frame_start.
